// File: rtl/multi_cycle_alu.sv
// Multi-cycle ALU: single-cycle add/sub/shift/logic ops, iterative shift-add
// multiply and restoring divide taking WIDTH steps each.
module multi_cycle_alu #(
    parameter int WIDTH = 4,
    parameter int SHW   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [SHW-1:0]   inC,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ans,
    output logic [WIDTH-1:0] ans_hi,
    output logic             dz
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int CW = $clog2(WIDTH) + 1;

    state_t            state, nextState;
    logic [CW-1:0]     cnt;
    logic              opDiv;
    logic [WIDTH-1:0]  aReg, bReg;
    // Working pair: multiply {partial high, multiplier/product low},
    // divide {remainder, dividend/quotient shift register}.
    logic [WIDTH-1:0]  hiReg, loReg;

    logic [WIDTH-1:0]  quick;
    logic [WIDTH:0]    mulSum, divTrial, divDiff;
    logic              divGe, lastStep, isLong;
    logic [WIDTH-1:0]  stepHi, stepLo;

    assign isLong   = (op[2:1] == 2'b11);
    assign lastStep = (cnt == CW'(WIDTH - 1));

    always_comb begin
        quick = '0;
        case (op)
            3'd0: quick = inA + inB;
            3'd1: quick = inA - inB;
            3'd2: quick = inA >> inC;
            3'd3: quick = $signed(inA) >>> inC;
            3'd4: quick = inA & inB;
            3'd5: quick = inA | inB;
            default: quick = '0;
        endcase
    end

    always_comb begin
        mulSum   = {1'b0, hiReg} + (loReg[0] ? {1'b0, aReg} : '0);
        divTrial = {hiReg, loReg[WIDTH-1]};
        divGe    = (divTrial >= {1'b0, bReg});
        divDiff  = divTrial - {1'b0, bReg};
        if (opDiv) begin
            stepHi = divGe ? divDiff[WIDTH-1:0] : divTrial[WIDTH-1:0];
            stepLo = {loReg[WIDTH-2:0], divGe};
        end else begin
            stepHi = mulSum[WIDTH:1];
            stepLo = {mulSum[0], loReg[WIDTH-1:1]};
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (start) nextState = isLong ? RUN : DONE;
            RUN:  if (lastStep) nextState = DONE;
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            opDiv  <= 1'b0;
            aReg   <= '0;
            bReg   <= '0;
            hiReg  <= '0;
            loReg  <= '0;
            ans    <= '0;
            ans_hi <= '0;
            dz     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    opDiv <= op[0];
                    aReg  <= inA;
                    bReg  <= inB;
                    cnt   <= '0;
                    if (isLong) begin
                        hiReg <= '0;
                        loReg <= op[0] ? inA : inB;
                    end else begin
                        ans    <= quick;
                        ans_hi <= '0;
                        dz     <= 1'b0;
                    end
                end
                RUN: begin
                    hiReg <= stepHi;
                    loReg <= stepLo;
                    cnt   <= cnt + 1'b1;
                    if (lastStep) begin
                        // Divide by zero reports all-ones quotient, dividend as remainder.
                        if (opDiv && bReg == '0) begin
                            ans    <= '1;
                            ans_hi <= aReg;
                            dz     <= 1'b1;
                        end else begin
                            ans    <= stepLo;
                            ans_hi <= stepHi;
                            dz     <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
